// File: rtl/regfilemux.sv
// Writeback result selector shared by decode, execute and the MEM/WB stage.
package regfilemux;

    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;

endpackage

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: funct3 encodings, control word, MEM-stage FSM state and store lane helpers.
package rv32i_types;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                        load_regfile;
        logic                        data_read;
        logic                        data_write;
        regfilemux::regfilemux_sel_t regfilemux_sel;
    } rv32i_control_word;

    function automatic logic [3:0] store_mbe(input store_funct3_t funct3, input logic [1:0] off);
        logic [3:0] mbe;
        case (funct3)
            sw:      mbe = 4'b1111;
            sh:      mbe = 4'b0011 << {off[1], 1'b0};
            sb:      mbe = 4'b0001 << off;
            default: mbe = 4'b0000;
        endcase
        return mbe;
    endfunction

    // Store data is replicated into the addressed lane by shifting; bytes outside the lane are masked by mbe.
    function automatic logic [31:0] store_wdata(input store_funct3_t funct3, input logic [1:0] off,
                                                input logic [31:0] rs2);
        logic [31:0] wdata;
        case (funct3)
            sw:      wdata = rs2;
            sh:      wdata = rs2 << {off[1], 4'b0000};
            sb:      wdata = rs2 << {off, 3'b000};
            default: wdata = rs2;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load extraction: moves the addressed byte/half of the read word to bit 0 and extends it per load type.
module load_align (
    input  logic [31:0]                 data_rdata,
    input  logic [1:0]                  off,
    input  regfilemux::regfilemux_sel_t regfilemux_sel,
    output logic [31:0]                 load_val
);

    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;

    assign byte_lane_s = 8'(data_rdata >> {off, 3'b000});
    assign half_lane_s = 16'(data_rdata >> {off[1], 4'b0000});

    // Extend the selected lane; lw always takes the whole word regardless of offset.
    always_comb begin
        load_val = data_rdata;
        case (regfilemux_sel)
            regfilemux::lw:  load_val = data_rdata;
            regfilemux::lb:  load_val = {{24{byte_lane_s[7]}}, byte_lane_s};
            regfilemux::lbu: load_val = {24'd0, byte_lane_s};
            regfilemux::lh:  load_val = {{16{half_lane_s[15]}}, half_lane_s};
            regfilemux::lhu: load_val = {16'd0, half_lane_s};
            default:         load_val = data_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage of the rv32i pipeline: data-memory handshake FSM, store lane alignment,
// load extraction and the MEM/WB register feeding the regfile write port.
module mem_wb_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_mem,
    input  rv32i_control_word ctrl_mem,
    input  logic [2:0]        funct3_mem,
    input  logic [4:0]        rd_mem,
    input  logic [31:0]       alu_out_mem,
    input  logic              br_en_mem,
    input  logic [31:0]       u_imm_mem,
    input  logic [31:0]       pc_mem,
    input  logic [31:0]       rs2_out_mem,
    input  logic [31:0]       data_rdata,
    input  logic              data_resp,
    output logic              data_read,
    output logic              data_write,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_mbe,
    output logic [31:0]       data_wdata,
    output logic              stall_out,
    output logic [4:0]        rd_wb,
    output logic              load_regfile_wb,
    output logic [31:0]       regfilemux_out_wb
);

    mem_state_t state_q, state_d;

    // Snapshot of the in-flight access, so the bus and writeback info stay put while in WAIT.
    logic                        hold_read_q, hold_read_d;
    logic                        hold_write_q, hold_write_d;
    logic                        hold_load_q, hold_load_d;
    logic [31:0]                 hold_addr_q, hold_addr_d;
    logic [31:0]                 hold_wdata_q, hold_wdata_d;
    logic [3:0]                  hold_mbe_q, hold_mbe_d;
    logic [1:0]                  hold_off_q, hold_off_d;
    logic [4:0]                  hold_rd_q, hold_rd_d;
    regfilemux::regfilemux_sel_t hold_sel_q, hold_sel_d;

    logic                        new_read_s, new_write_s;
    logic [1:0]                  new_off_s;
    logic [3:0]                  new_mbe_s;
    logic [31:0]                 new_wdata_s;

    logic                        cur_valid_s, cur_read_s, cur_write_s, cur_load_s, cur_req_s;
    logic [31:0]                 cur_addr_s, cur_wdata_s;
    logic [3:0]                  cur_mbe_s;
    logic [1:0]                  cur_off_s;
    logic [4:0]                  cur_rd_s;
    regfilemux::regfilemux_sel_t cur_sel_s;

    logic                        stall_s, capture_s, wb_load_s;
    logic [31:0]                 load_val_s, result_s;

    logic [4:0]                  rd_wb_q, rd_wb_d;
    logic                        load_wb_q, load_wb_d;
    logic [31:0]                 value_wb_q, value_wb_d;

    assign new_read_s  = valid_mem & ctrl_mem.data_read;
    assign new_write_s = valid_mem & ctrl_mem.data_write;
    assign new_off_s   = alu_out_mem[1:0];

    // Byte enables and lane-shifted store data for the instruction currently presented.
    always_comb begin
        new_mbe_s   = 4'b0000;
        new_wdata_s = rs2_out_mem;
        if (new_write_s) begin
            new_mbe_s   = store_mbe(store_funct3_t'(funct3_mem), new_off_s);
            new_wdata_s = store_wdata(store_funct3_t'(funct3_mem), new_off_s, rs2_out_mem);
        end else begin
            new_mbe_s   = 4'b0000;
            new_wdata_s = rs2_out_mem;
        end
    end

    // Current access view: live EX/MEM fields in IDLE, the captured snapshot in WAIT.
    always_comb begin
        cur_valid_s = valid_mem;
        cur_read_s  = new_read_s;
        cur_write_s = new_write_s;
        cur_load_s  = ctrl_mem.load_regfile;
        cur_addr_s  = {alu_out_mem[31:2], 2'b00};
        cur_wdata_s = new_wdata_s;
        cur_mbe_s   = new_mbe_s;
        cur_off_s   = new_off_s;
        cur_rd_s    = rd_mem;
        cur_sel_s   = ctrl_mem.regfilemux_sel;
        if (state_q == WAIT) begin
            cur_valid_s = 1'b1;
            cur_read_s  = hold_read_q;
            cur_write_s = hold_write_q;
            cur_load_s  = hold_load_q;
            cur_addr_s  = hold_addr_q;
            cur_wdata_s = hold_wdata_q;
            cur_mbe_s   = hold_mbe_q;
            cur_off_s   = hold_off_q;
            cur_rd_s    = hold_rd_q;
            cur_sel_s   = hold_sel_q;
        end else begin
            cur_valid_s = valid_mem;
        end
    end

    assign cur_req_s = cur_read_s | cur_write_s;
    assign stall_s   = cur_req_s & ~data_resp;
    assign capture_s = (state_q == IDLE) & stall_s;

    // Handshake FSM next state: a same-cycle response never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (stall_s) state_d = WAIT;
                else         state_d = IDLE;
            end
            WAIT: begin
                if (data_resp) state_d = IDLE;
                else           state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot next value: load on entry to WAIT, otherwise hold.
    always_comb begin
        hold_read_d  = hold_read_q;
        hold_write_d = hold_write_q;
        hold_load_d  = hold_load_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_mbe_d   = hold_mbe_q;
        hold_off_d   = hold_off_q;
        hold_rd_d    = hold_rd_q;
        hold_sel_d   = hold_sel_q;
        if (capture_s) begin
            hold_read_d  = cur_read_s;
            hold_write_d = cur_write_s;
            hold_load_d  = cur_load_s;
            hold_addr_d  = cur_addr_s;
            hold_wdata_d = cur_wdata_s;
            hold_mbe_d   = cur_mbe_s;
            hold_off_d   = cur_off_s;
            hold_rd_d    = cur_rd_s;
            hold_sel_d   = cur_sel_s;
        end else begin
            hold_read_d  = hold_read_q;
        end
    end

    load_align u_load_align (
        .data_rdata     (data_rdata),
        .off            (cur_off_s),
        .regfilemux_sel (cur_sel_s),
        .load_val       (load_val_s)
    );

    // Writeback value select.
    always_comb begin
        result_s = alu_out_mem;
        case (cur_sel_s)
            regfilemux::alu_out:  result_s = alu_out_mem;
            regfilemux::br_en:    result_s = {31'd0, br_en_mem};
            regfilemux::u_imm:    result_s = u_imm_mem;
            regfilemux::pc_plus4: result_s = pc_mem + 32'd4;
            regfilemux::lw,
            regfilemux::lb,
            regfilemux::lbu,
            regfilemux::lh,
            regfilemux::lhu:      result_s = load_val_s;
            default:              result_s = alu_out_mem;
        endcase
    end

    assign wb_load_s = cur_valid_s & cur_load_s & (cur_rd_s != 5'd0) & ~cur_write_s;

    // MEM/WB next value: a stalled or empty slot becomes a bubble so no write is ever repeated.
    always_comb begin
        rd_wb_d    = 5'd0;
        load_wb_d  = 1'b0;
        value_wb_d = 32'd0;
        if (stall_s || !cur_valid_s) begin
            rd_wb_d    = 5'd0;
            load_wb_d  = 1'b0;
            value_wb_d = 32'd0;
        end else begin
            rd_wb_d    = cur_rd_s;
            load_wb_d  = wb_load_s;
            value_wb_d = result_s;
        end
    end

    // State, snapshot and MEM/WB registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_read_q  <= 1'b0;
            hold_write_q <= 1'b0;
            hold_load_q  <= 1'b0;
            hold_addr_q  <= 32'd0;
            hold_wdata_q <= 32'd0;
            hold_mbe_q   <= 4'b0000;
            hold_off_q   <= 2'b00;
            hold_rd_q    <= 5'd0;
            hold_sel_q   <= regfilemux::alu_out;
            rd_wb_q      <= 5'd0;
            load_wb_q    <= 1'b0;
            value_wb_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            hold_read_q  <= hold_read_d;
            hold_write_q <= hold_write_d;
            hold_load_q  <= hold_load_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_mbe_q   <= hold_mbe_d;
            hold_off_q   <= hold_off_d;
            hold_rd_q    <= hold_rd_d;
            hold_sel_q   <= hold_sel_d;
            rd_wb_q      <= rd_wb_d;
            load_wb_q    <= load_wb_d;
            value_wb_q   <= value_wb_d;
        end
    end

    assign data_read         = cur_read_s;
    assign data_write        = cur_write_s;
    assign data_addr         = cur_addr_s;
    assign data_mbe          = cur_write_s ? cur_mbe_s : 4'b0000;
    assign data_wdata        = cur_wdata_s;
    assign stall_out         = stall_s;
    assign rd_wb             = rd_wb_q;
    assign load_regfile_wb   = load_wb_q;
    assign regfilemux_out_wb = value_wb_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the rv32i pipeline. It consumes the EX/MEM control word and operands, drives the data-memory request/response handshake with byte enables and alignment, and stalls upstream stages while an access is outstanding. It registers the MEM/WB result and drives the regfile write port (`rd_wb`, `load_regfile_wb`, `regfilemux_out_wb`) read by the decode stage.

## Interface
Parameters: none.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_mem` in 1: EX/MEM holds a real instruction (0 = bubble).
- `ctrl_mem` in `rv32i_control_word`: control word of that instruction.
- `funct3_mem` in 3: store width select (`sb`/`sh`/`sw`).
- `rd_mem` in 5: destination register.
- `alu_out_mem` in 32: ALU result / effective address.
- `br_en_mem` in 1: compare result (slt/sltu).
- `u_imm_mem` in 32: U-type immediate.
- `pc_mem` in 32: PC of the instruction.
- `rs2_out_mem` in 32: store data.
- `data_rdata` in 32: memory read data.
- `data_resp` in 1: memory completion, one cycle.
- `data_read` out 1, `data_write` out 1: memory request.
- `data_addr` out 32: word-aligned address.
- `data_mbe` out 4: byte enables.
- `data_wdata` out 32: lane-shifted store data.
- `stall_out` out 1: freeze IF/ID/EX/MEM registers.
- `rd_wb` out 5, `load_regfile_wb` out 1, `regfilemux_out_wb` out 32: regfile write port.

## Operation
- FSM states: `IDLE`, `WAIT`.
- `IDLE`: if `valid_mem` and (`ctrl_mem.data_read` | `ctrl_mem.data_write`), assert the matching request this cycle.
  - If `data_resp` is also high this cycle, stay in `IDLE`. Otherwise go to `WAIT`.
- `WAIT`: hold the request and all request fields stable. On `data_resp`, return to `IDLE`.
- `stall_out` = request asserted && !`data_resp`.
- `data_resp` with no request pending is ignored.
- Address and offset:
  - `data_addr` = {`alu_out_mem[31:2]`, 2'b00}; `off` = `alu_out_mem[1:0]`.
- Stores:
  - `sw`: mbe 4'b1111; wdata = rs2.
  - `sh`: mbe 4'b0011 << {off[1],1'b0}; wdata = rs2 << 16*off[1].
  - `sb`: mbe 4'b0001 << off; wdata = rs2 << 8*off.
- Loads use `shifted` = `data_rdata` >> 8*off:
  - `lw` ignores off; `lh`/`lhu` use off[1] only.
  - `lb`/`lh` sign-extend; `lbu`/`lhu` zero-extend.
- Result select by `ctrl_mem.regfilemux_sel`:
  - `alu_out` → alu_out; `br_en` → {31'b0, br_en}; `u_imm` → u_imm; `pc_plus4` → pc+4; load selects → extended data.
- `load_regfile_wb` = `valid_mem` & `ctrl_mem.load_regfile` & (`rd_mem` != 0).
- `data_mbe` = 0 when not writing.

## Timing
- Reset: state `IDLE`. Outputs `rd_wb`, `load_regfile_wb`, `regfilemux_out_wb` = 0.
  - `data_read`, `data_write`, `data_mbe`, `stall_out` = 0 in the cycle after `rst` is sampled.
  - Reset mid-`WAIT` abandons the access; a late `data_resp` is ignored.
- MEM/WB register loads on every edge with `stall_out` = 0.
  - It loads a bubble (`load_regfile_wb` = 0) when `valid_mem` = 0.
  - It also loads a bubble while stalled, so no stale write repeats.
- Latency:
  - Non-memory op: writeback visible 1 cycle after it is presented.
  - Load/store: writeback visible 1 cycle after the `data_resp` cycle.
- Store writeback carries `load_regfile_wb` = 0.
- Back-to-back memory ops: the next request may assert in the cycle after `data_resp`. No dead cycle is required beyond that.
- Read data is sampled only in the `data_resp` cycle.

## Structure
- Shared package `rv32i_types` additions:
  - `mem_state_t` {IDLE, WAIT}.
  - `regfilemux::pc_plus4` if not already present.
  - Reuse `store_funct3_t` and `load_funct3_t`.
- Sub-module `load_align`: combinational.
  - Inputs: `data_rdata`, `off`, `regfilemux_sel`.
  - Output: extended 32-bit load value.
- FSM, byte-enable/store shifting and MEM/WB register stay in `mem_wb_stage`.

## Test plan
- `lb` at addr 0x103, rdata 0x80FF_FFFF, `data_resp` after 3 cycles:
  - data_addr 0x100; stall_out high 3 cycles.
  - Next cycle: `regfilemux_out_wb` 0xFFFF_FF80, `load_regfile_wb` 1.
- `sh` rs2 0x1234_ABCD to addr 0x202: mbe 4'b1100, wdata 0xABCD_0000, same-cycle `data_resp` → no stall; writeback `load_regfile_wb` 0.
- `sltu` with `br_en_mem` 1, rd 5 → next cycle `rd_wb` 5, value 0x0000_0001.
- `lui` to rd 0 → `load_regfile_wb` 0.
- `rst` asserted in `WAIT` → next cycle no request, stall_out 0, all outputs 0; `data_resp` one cycle later → no writeback.
- `lhu` at 0x0, rdata 0x0000_F00D, then a valid `add` held during the stall:
  - `lhu` writes 0x0000_F00D once.
  - `add` writes back exactly once, 1 cycle later.
